// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scanning one-hot decoder: FSM states, mode
// encodings and the output-width helper.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int out_width(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational AW -> 2^AW one-hot decoder; output is all-zero when en is low.
module onehot_dec #(
  parameter int AW = 4
) (
  input  logic               en,
  input  logic [AW-1:0]      addr,
  output logic [(2**AW)-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[addr] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a valid/ready request port and an auto-scan
// mode that steps the selected output with a programmable dwell time.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter  int AW      = 4,
  parameter  int DWELL_W = 8,
  localparam int OW      = out_width(AW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      in_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OW-1:0]      y,
  output logic [AW-1:0]      idx,
  output logic               wrap,
  output logic               busy
);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               wrap_d;
  logic               sel_en;
  logic [OW-1:0]      y_d;
  logic               accept;

  assign in_ready = en & (state_q != SCAN);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == SCAN);

  // sel_en decides whether next cycle's y shows one-hot(idx_d) or zero;
  // y is computed from the next index so it is registered alongside idx.
  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    sel_en  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      idx_d  = in_addr;
      sel_en = 1'b1;
      if (mode == MODE_SCAN) begin
        state_d = SCAN;
        cnt_d   = dwell;
        dwell_d = dwell;
      end else begin
        state_d = HOLD;
      end
    end else begin
      case (state_q)
        HOLD: sel_en = 1'b1;
        SCAN: begin
          sel_en = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else begin
            idx_d  = idx + AW'(1);
            cnt_d  = dwell_q;
            wrap_d = (idx == '1);
          end
        end
        default: sel_en = 1'b0;
      endcase
    end
  end

  onehot_dec #(.AW(AW)) u_dec (
    .en   (sel_en),
    .addr (idx_d),
    .y    (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx     <= '0;
      y       <= '0;
      wrap    <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      y       <= y_d;
      wrap    <= wrap_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: directed vectors push expected outputs per
// cycle, a negedge monitor pops and compares; extra AW=2/AW=5 instances are swept.
module tb_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, in_valid;
  logic [3:0]  in_addr;
  logic [7:0]  dwell;
  logic        in_ready, wrap, busy;
  logic [15:0] y;
  logic [3:0]  idx;

  logic        v2, rdy2, wrap2, busy2;
  logic [1:0]  a2, idx2;
  logic [3:0]  y2;
  logic        v5, rdy5, wrap5, busy5;
  logic [4:0]  a5, idx5;
  logic [31:0] y5;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        wrap;
    logic        busy;
    logic        ready;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  scan_decoder #(.AW(4), .DWELL_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_addr(in_addr), .dwell(dwell), .y(y), .idx(idx),
    .wrap(wrap), .busy(busy)
  );

  scan_decoder #(.AW(2), .DWELL_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(1'b0), .in_valid(v2),
    .in_ready(rdy2), .in_addr(a2), .dwell(8'd0), .y(y2), .idx(idx2),
    .wrap(wrap2), .busy(busy2)
  );

  scan_decoder #(.AW(5), .DWELL_W(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(1'b0), .in_valid(v5),
    .in_ready(rdy5), .in_addr(a5), .dwell(8'd0), .y(y5), .idx(idx5),
    .wrap(wrap5), .busy(busy5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [3:0] a,
                               input logic m, input logic [7:0] d);
    @(negedge clk);
    #1;
    en       = e;
    in_valid = v;
    in_addr  = a;
    mode     = m;
    dwell    = d;
  endtask

  task automatic push_expect(input int c, input logic [3:0] i, input logic y_on,
                             input logic w, input logic b, input logic r, input string name);
    exp_t e;
    e.cyc   = c;
    e.idx   = i;
    e.y     = y_on ? (16'd1 << i) : 16'd0;
    e.wrap  = w;
    e.busy  = b;
    e.ready = r;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Pop every expectation due this cycle; anything overdue is reported too.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        checkOutput({mon_e.name, "_missed_cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end else begin
        checkOutput({mon_e.name, "_y"}, 32'(y), 32'(mon_e.y));
        checkOutput({mon_e.name, "_idx"}, 32'(idx), 32'(mon_e.idx));
        checkOutput({mon_e.name, "_wrap"}, 32'(wrap), 32'(mon_e.wrap));
        checkOutput({mon_e.name, "_busy"}, 32'(busy), 32'(mon_e.busy));
        checkOutput({mon_e.name, "_ready"}, 32'(in_ready), 32'(mon_e.ready));
      end
    end
  end

  // y must be zero or one-hot every cycle, and when set it must match idx.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("inv_onehot0", 32'($onehot0(y)), 32'd1);
      checkOutput("inv_onehot0_aw2", 32'($onehot0(y2)), 32'd1);
      checkOutput("inv_onehot0_aw5", 32'($onehot0(y5)), 32'd1);
      if (y != '0) checkOutput("inv_y_idx", 32'(y), 32'd1 << idx);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_addr = '0; dwell = '0;
    v2 = 1'b0; a2 = '0; v5 = 1'b0; a5 = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("ready_en_low", 32'(in_ready), 32'd0);

    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd0, 0, 0, 0, 1, "idle_after_reset");

    // Direct decode, including back-to-back accepts.
    applyStimulus(1, 1, 4'd5, 0, 8'd0);
    push_expect(cyc + 1, 4'd5, 1, 0, 0, 1, "direct5");
    applyStimulus(1, 1, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd0, 1, 0, 0, 1, "direct0");
    applyStimulus(1, 1, 4'd15, 0, 8'd0);
    push_expect(cyc + 1, 4'd15, 1, 0, 0, 1, "direct15");
    applyStimulus(1, 1, 4'd9, 0, 8'd0);
    push_expect(cyc + 1, 4'd9, 1, 0, 0, 1, "direct9");
    applyStimulus(1, 0, 4'd3, 0, 8'd0);
    push_expect(cyc + 1, 4'd9, 1, 0, 0, 1, "hold9");

    // Scan from 14 with dwell 0 across the wrap point.
    applyStimulus(1, 1, 4'd14, 1, 8'd0);
    push_expect(cyc + 1, 4'd14, 1, 0, 1, 0, "scan14");
    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd15, 1, 0, 1, 0, "scan15");
    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd0, 1, 1, 1, 0, "scan_wrap0");
    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd1, 1, 0, 1, 0, "scan1");
    applyStimulus(0, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd1, 0, 0, 0, 0, "stop_at1");
    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd1, 0, 0, 0, 1, "reenable_idle");

    // Dwell 2 from index 3; dwell input moved to 7 and in_valid held mid-scan.
    applyStimulus(1, 1, 4'd3, 1, 8'd2);
    push_expect(cyc + 1, 4'd3, 1, 0, 1, 0, "dwell_start3");
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1, 1, 4'd0, 0, 8'd7);
      push_expect(cyc + 1, 4'(3 + i / 3), 1, 0, 1, 0, "dwell_step");
    end

    // Drop en at idx 7, then re-enable and accept again.
    applyStimulus(0, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd7, 0, 0, 0, 0, "stop_at7");
    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd7, 0, 0, 0, 1, "restart_idle_a");
    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd7, 0, 0, 0, 1, "restart_idle_b");
    applyStimulus(1, 1, 4'd2, 0, 8'd0);
    push_expect(cyc + 1, 4'd2, 1, 0, 0, 1, "restart_direct2");

    // Asynchronous reset in the middle of a scan.
    applyStimulus(1, 1, 4'd10, 1, 8'd0);
    push_expect(cyc + 1, 4'd10, 1, 0, 1, 0, "scan10");
    applyStimulus(1, 0, 4'd0, 0, 8'd0);
    push_expect(cyc + 1, 4'd11, 1, 0, 1, 0, "scan11");
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'($urandom);
    mode     = 1'($urandom);
    in_addr  = 4'($urandom);
    dwell    = 8'($urandom);
    #1;
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_idx", 32'(idx), 32'd0);
    checkOutput("rst_wrap", 32'(wrap), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0;
    push_expect(cyc + 1, 4'd0, 0, 0, 0, 1, "after_async_reset");

    // Direct sweeps on the AW=2 and AW=5 instances.
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      #1;
      v2 = 1'b1;
      a2 = 2'(a);
      @(negedge clk);
      checkOutput("sweep2_y", 32'(y2), 32'd1 << a);
      checkOutput("sweep2_idx", 32'(idx2), 32'(a));
    end
    v2 = 1'b0;
    checkOutput("sweep2_flags", {29'd0, rdy2, wrap2, busy2}, 32'd4);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      #1;
      v5 = 1'b1;
      a5 = 5'(a);
      @(negedge clk);
      checkOutput("sweep5_y", y5, 32'd1 << a);
      checkOutput("sweep5_idx", 32'(idx5), 32'(a));
    end
    v5 = 1'b0;
    checkOutput("sweep5_flags", {29'd0, rdy5, wrap5, busy5}, 32'd4);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parameterised, registered N-to-2^N one-hot decoder with an enable.
- Adds a valid/ready address handshake and an auto-scan mode: starting from a loaded index, the one-hot output steps through all outputs with a programmable dwell time.
- Drives row/bank/chip selects and multiplexed display or keypad scanning in the datapath.

Parameters:
- AW, 4, address width; output width is 2^AW.
- DWELL_W, 8, width of the dwell-count input and internal dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; low forces outputs to zero and stops scanning.
- mode  input  1  0 = direct, 1 = scan; sampled only on handshake accept.
- in_valid  input  1  in_addr/mode/dwell are valid.
- in_ready  output  1  block accepts a new request.
- in_addr  input  AW  direct address, or scan start index.
- dwell  input  DWELL_W  scan dwell; each index is held dwell+1 cycles.
- y  output  2^AW  registered one-hot select; y[0] corresponds to index 0.
- idx  output  AW  currently selected index (registered).
- wrap  output  1  one-cycle pulse when the scan index rolls from 2^AW-1 to 0.
- busy  output  1  high while in SCAN.

Behaviour:
- Reset (async, rst_n=0): y=0, idx=0, wrap=0, busy=0, dwell counter=0, state=IDLE. Reset mid-scan aborts immediately with no completion pulse.
- States: IDLE, HOLD, SCAN.
- in_ready = en & (state != SCAN). Combinational from state and en.
- accept = in_valid & in_ready.
- IDLE/HOLD, accept with mode=0:
  - Next cycle: idx=in_addr, y=one-hot(in_addr), state=HOLD.
  - Latency 1 cycle.
  - Back-to-back accepts update every cycle.
- IDLE/HOLD, accept with mode=1:
  - Next cycle: idx=in_addr, y=one-hot(in_addr), dwell counter=dwell (captured), state=SCAN, busy=1.
- SCAN, counter != 0: counter decrements by 1 each cycle; idx and y hold.
- SCAN, counter == 0:
  - Next cycle: idx=(idx+1) mod 2^AW, y updates to match, counter reloads the captured dwell.
  - dwell=0 advances every cycle.
  - Mode and dwell input changes during SCAN are ignored.
- wrap: registered; asserted in the same cycle idx first shows 0 after showing 2^AW-1 in SCAN. Never asserted in direct mode. Starting a scan at index 0 does not pulse wrap.
- SCAN runs indefinitely until en drops.
- en=0, in any state:
  - Next cycle: y=0, wrap=0, state=IDLE, busy=0.
  - idx retains its last value; the dwell counter clears.
  - in_ready=0 while en=0.
- en rising again: state is IDLE, y stays 0 until a new accept.
- in_valid while in_ready=0 is ignored; the request is not queued. The source must hold the request until accepted.
- Invariant: y is always either all-zero or exactly one-hot, and equals one-hot(idx) whenever state != IDLE.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, HOLD, SCAN};
  - mode constants MODE_DIRECT=0 and MODE_SCAN=1;
  - a function returning 2^AW.
- Sub-module onehot_dec: parameterised combinational AW -> 2^AW decoder with an enable input. The registered top instantiates it on the next-index value.
- The dwell counter and FSM stay in the top.

Test Plan:
1. Reset check: assert rst_n=0 mid-cycle with random inputs -> y=0, idx=0, wrap=0, busy=0 immediately; after release, in_ready=1 once en=1.
2. Direct decode (AW=4): accept addr 5 -> next cycle y=16'h0020, idx=5. Then accept 0, 15, 9 on consecutive cycles -> y=0x0001, 0x8000, 0x0200 on consecutive cycles.
3. Scan wrap (AW=4): start index 14, dwell=0, mode=1 -> idx sequence 14, 15, 0, 1. wrap=1 only in the cycle idx=0; in_ready=0 and busy=1 throughout.
4. Dwell timing: start index 3, dwell=2 -> idx=3 for 3 cycles, then 4 for 3 cycles. Changing the dwell input to 7 mid-scan -> no effect on timing.
5. Stop/restart: drop en mid-scan at idx=7 -> next cycle y=0, busy=0, idx stays 7. Raise en -> y stays 0 until accept; in_valid asserted during SCAN is ignored.
6. Exhaustive sweep with AW=2 and AW=5: direct-accept every address -> y has exactly one bit set at the addressed position. One-hot/zero assertion held on every cycle.
